// File: rtl/pong_game_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_fsm
// Purpose  : Pong game sequencer. Owns paddle/ball positions, bounces, scoring
//            and the SERVE/PLAY/GAMEOVER state machine; advances once per
//            slowclock tick. Outputs are top-left pixel coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_fsm #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_W    = 20,
  parameter int PADDLE_H    = 100,
  parameter int BALL_SZ     = 20,
  parameter int PL_X        = 100,
  parameter int PR_X        = 500,
  parameter int PADDLE_VEL  = 10,
  parameter int BALL_VEL    = 3,
  parameter int SERVE_DELAY = 30,
  parameter int WIN_SCORE   = 7
) (
  input  logic        slowclock,
  input  logic        iRST_n,
  input  logic        pL_moveup,
  input  logic        pL_movedown,
  input  logic        pR_moveup,
  input  logic        pR_movedown,
  output logic [11:0] pL_ypos,
  output logic [11:0] pR_ypos,
  output logic [11:0] b_xpos,
  output logic [11:0] b_ypos,
  output logic [3:0]  score_L,
  output logic [3:0]  score_R,
  output logic [1:0]  game_state,
  output logic        winner
);

  // Derived geometry, all in the 12-bit coordinate space
  localparam logic [11:0] PADDLE_MAX = 12'(SCREEN_H - PADDLE_H);
  localparam logic [11:0] PVEL       = 12'(PADDLE_VEL);
  localparam logic [11:0] BVEL       = 12'(BALL_VEL);
  localparam logic [11:0] BSZ        = 12'(BALL_SZ);
  localparam logic [11:0] PH         = 12'(PADDLE_H);
  localparam logic [11:0] BY_MAX     = 12'(SCREEN_H - BALL_SZ);
  localparam logic [11:0] BX_MAX     = 12'(SCREEN_W - BALL_SZ);
  localparam logic [11:0] L_EDGE     = 12'(PL_X + PADDLE_W);
  localparam logic [11:0] R_EDGE     = 12'(PR_X - BALL_SZ);
  localparam logic [11:0] CENTRE_X   = 12'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [11:0] CENTRE_Y   = 12'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [11:0] PADDLE_Y0  = 12'((SCREEN_H - PADDLE_H) / 2);
  localparam int          CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_SERVE    = 2'b00,
    ST_PLAY     = 2'b01,
    ST_GAMEOVER = 2'b10
  } state_t;

  state_t           state, state_nx;
  logic [11:0]      pl_y, pl_y_nx, pr_y, pr_y_nx;
  logic [11:0]      bx, bx_nx, by, by_nx;
  logic             dx_left, dx_left_nx;   // 1 = ball travelling left
  logic             dy_up, dy_up_nx;       // 1 = ball travelling up
  logic [3:0]       sl, sl_nx, sr, sr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             win, win_nx;
  logic             ov_l, ov_r;

  // One paddle step with clamping; compare first so nothing wraps
  function automatic logic [11:0] paddle_step(input logic [11:0] y,
                                              input logic up_n,
                                              input logic down_n);
    paddle_step = y;
    if (!up_n && down_n)
      paddle_step = (y < PVEL) ? 12'd0 : y - PVEL;
    else if (up_n && !down_n)
      paddle_step = (y + PVEL > PADDLE_MAX) ? PADDLE_MAX : y + PVEL;
  endfunction

  // Vertical overlap of the ball with each paddle, using pre-update positions
  assign ov_l = (by + BSZ > pl_y) && (by < pl_y + PH);
  assign ov_r = (by + BSZ > pr_y) && (by < pr_y + PH);

  // Game state register; asynchronous reset restores the serve position
  always_ff @(posedge slowclock or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= ST_SERVE;
      pl_y    <= PADDLE_Y0;
      pr_y    <= PADDLE_Y0;
      bx      <= CENTRE_X;
      by      <= CENTRE_Y;
      dx_left <= 1'b0;
      dy_up   <= 1'b0;
      sl      <= '0;
      sr      <= '0;
      cnt     <= '0;
      win     <= 1'b0;
    end else begin
      state   <= state_nx;
      pl_y    <= pl_y_nx;
      pr_y    <= pr_y_nx;
      bx      <= bx_nx;
      by      <= by_nx;
      dx_left <= dx_left_nx;
      dy_up   <= dy_up_nx;
      sl      <= sl_nx;
      sr      <= sr_nx;
      cnt     <= cnt_nx;
      win     <= win_nx;
    end
  end

  // Next-state logic: paddles, serve timer, ball motion, bounces and scoring
  always_comb begin
    state_nx   = state;
    pl_y_nx    = pl_y;
    pr_y_nx    = pr_y;
    bx_nx      = bx;
    by_nx      = by;
    dx_left_nx = dx_left;
    dy_up_nx   = dy_up;
    sl_nx      = sl;
    sr_nx      = sr;
    cnt_nx     = cnt;
    win_nx     = win;

    case (state)
      ST_SERVE: begin
        pl_y_nx = paddle_step(pl_y, pL_moveup, pL_movedown);
        pr_y_nx = paddle_step(pr_y, pR_moveup, pR_movedown);
        bx_nx   = CENTRE_X;
        by_nx   = CENTRE_Y;
        if (cnt == SERVE_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_PLAY;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      ST_PLAY: begin
        pl_y_nx = paddle_step(pl_y, pL_moveup, pL_movedown);
        pr_y_nx = paddle_step(pr_y, pR_moveup, pR_movedown);

        // Vertical axis: top/bottom wall bounce
        if (dy_up) begin
          if (by < BVEL) begin
            by_nx    = 12'd0;
            dy_up_nx = 1'b0;
          end else begin
            by_nx = by - BVEL;
          end
        end else begin
          if (by + BVEL > BY_MAX) begin
            by_nx    = BY_MAX;
            dy_up_nx = 1'b1;
          end else begin
            by_nx = by + BVEL;
          end
        end

        // Horizontal axis: paddle hit beats miss beats plain step
        if (dx_left && (bx >= L_EDGE) && (bx - BVEL <= L_EDGE) && ov_l) begin
          bx_nx      = L_EDGE;
          dx_left_nx = 1'b0;
        end else if (!dx_left && (bx <= R_EDGE) && (bx + BVEL >= R_EDGE) && ov_r) begin
          bx_nx      = R_EDGE;
          dx_left_nx = 1'b1;
        end else if (dx_left && (bx < BVEL)) begin
          // Right player scores; next serve heads toward the left (loser)
          sr_nx = sr + 1'b1;
          bx_nx = CENTRE_X;
          by_nx = CENTRE_Y;
          if (sr_nx == WIN) begin
            state_nx = ST_GAMEOVER;
            win_nx   = 1'b1;
          end else begin
            state_nx = ST_SERVE;
            cnt_nx   = '0;
          end
        end else if (!dx_left && (bx + BVEL > BX_MAX)) begin
          // Left player scores; next serve heads toward the right (loser)
          sl_nx = sl + 1'b1;
          bx_nx = CENTRE_X;
          by_nx = CENTRE_Y;
          if (sl_nx == WIN) begin
            state_nx = ST_GAMEOVER;
            win_nx   = 1'b0;
          end else begin
            state_nx = ST_SERVE;
            cnt_nx   = '0;
          end
        end else begin
          bx_nx = dx_left ? bx - BVEL : bx + BVEL;
        end
      end

      ST_GAMEOVER: begin
        // Everything frozen until reset
      end

      default: begin
        state_nx = ST_SERVE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign pL_ypos    = pl_y;
  assign pR_ypos    = pr_y;
  assign b_xpos     = bx;
  assign b_ypos     = by;
  assign score_L    = sl;
  assign score_R    = sr;
  assign game_state = state;
  assign winner     = win;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_fsm
// Purpose  : Self-checking bench for pong_game_fsm: directed serve/paddle
//            sequence, then randomized games against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_fsm;

  logic        slowclock = 1'b0;
  logic        iRST_n    = 1'b1;
  logic        pL_moveup = 1'b1, pL_movedown = 1'b1;
  logic        pR_moveup = 1'b1, pR_movedown = 1'b1;
  logic [11:0] pL_ypos, pR_ypos, b_xpos, b_ypos;
  logic [3:0]  score_L, score_R;
  logic [1:0]  game_state;
  logic        winner;

  pong_game_fsm dut (
    .slowclock  (slowclock),
    .iRST_n     (iRST_n),
    .pL_moveup  (pL_moveup),
    .pL_movedown(pL_movedown),
    .pR_moveup  (pR_moveup),
    .pR_movedown(pR_movedown),
    .pL_ypos    (pL_ypos),
    .pR_ypos    (pR_ypos),
    .b_xpos     (b_xpos),
    .b_ypos     (b_ypos),
    .score_L    (score_L),
    .score_R    (score_R),
    .game_state (game_state),
    .winner     (winner)
  );

  always #5 slowclock = ~slowclock;

  int checks   = 0;
  int failures = 0;

  // Reference model: signed integer positions, velocities as +1/-1
  int m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_st, m_cnt, m_win;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pl = 190; m_pr = 190; m_bx = 310; m_by = 230;
    m_vx = 1;   m_vy = 1;   m_sl = 0;   m_sr = 0;
    m_st = 0;   m_cnt = 0;  m_win = 0;
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Buttons are active-low; exactly one pressed moves the paddle
  function automatic int paddle_dir(input logic up_n, input logic down_n);
    if (!up_n && down_n) return -1;
    if (up_n && !down_n) return 1;
    return 0;
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + 20 > py) && (by < py + 100);
  endfunction

  // One game tick; btn = {pL_up, pL_down, pR_up, pR_down}
  task automatic model_step(input logic [3:0] btn);
    int npl, npr, nx, ny;
    if (m_st == 2) return;
    npl = clamp(m_pl + 10 * paddle_dir(btn[3], btn[2]), 0, 380);
    npr = clamp(m_pr + 10 * paddle_dir(btn[1], btn[0]), 0, 380);
    if (m_st == 0) begin
      m_bx = 310; m_by = 230;
      m_cnt++;
      if (m_cnt == 30) begin m_cnt = 0; m_st = 1; end
    end else begin
      ny = m_by + 3 * m_vy;
      if (ny < 0)        begin ny = 0;   m_vy = 1;  end
      else if (ny > 460) begin ny = 460; m_vy = -1; end
      nx = m_bx + 3 * m_vx;
      if (m_vx < 0 && m_bx >= 120 && nx <= 120 && overlaps(m_by, m_pl)) begin
        nx = 120; m_vx = 1;
      end else if (m_vx > 0 && m_bx <= 480 && nx >= 480 && overlaps(m_by, m_pr)) begin
        nx = 480; m_vx = -1;
      end else if (nx < 0 || nx > 620) begin
        if (nx < 0) m_sr++; else m_sl++;
        nx = 310; ny = 230;
        if (m_sl == 7 || m_sr == 7) begin
          m_st = 2; m_win = (m_sr == 7) ? 1 : 0;
        end else begin
          m_st = 0; m_cnt = 0;
        end
      end
      m_bx = nx; m_by = ny;
    end
    m_pl = npl; m_pr = npr;
  endtask

  task automatic compare_all();
    check_val("pL_ypos", int'(pL_ypos), m_pl);
    check_val("pR_ypos", int'(pR_ypos), m_pr);
    check_val("b_xpos", int'(b_xpos), m_bx);
    check_val("b_ypos", int'(b_ypos), m_by);
    check_val("score_L", int'(score_L), m_sl);
    check_val("score_R", int'(score_R), m_sr);
    check_val("game_state", int'(game_state), m_st);
    if (m_st == 2) check_val("winner", int'(winner), m_win);
  endtask

  task automatic tick(input logic [3:0] btn);
    {pL_moveup, pL_movedown, pR_moveup, pR_movedown} = btn;
    @(posedge slowclock);
    model_step(btn);
    #1;
    compare_all();
  endtask

  // Asserts reset between clock edges and checks outputs respond at once
  task automatic do_reset();
    @(negedge slowclock);
    iRST_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("rst_winner", int'(winner), 0);
    @(negedge slowclock);
    iRST_n = 1'b1;
  endtask

  // mode 0: both random; 1: right paddle parked at top; 2: left parked at bottom
  function automatic logic [3:0] rand_btn(input int mode);
    logic [1:0] l, r;
    l = 2'($urandom_range(0, 3));
    r = 2'($urandom_range(0, 3));
    if (mode == 1) r = 2'b01;
    if (mode == 2) l = 2'b10;
    return {l, r};
  endfunction

  initial begin
    int n;
    do_reset();

    // Serve hold then first step
    for (int i = 0; i < 30; i++) tick(4'b1111);
    check_val("serve_to_play", int'(game_state), 1);
    check_val("serve_hold_x", int'(b_xpos), 310);
    tick(4'b1111);
    check_val("first_step_x", int'(b_xpos), 313);
    check_val("first_step_y", int'(b_ypos), 233);

    // Left paddle up to the top clamp, right paddle down to the bottom clamp
    for (int i = 0; i < 25; i++) tick(4'b0110);
    check_val("pl_top_clamp", int'(pL_ypos), 0);
    check_val("pr_bot_clamp", int'(pR_ypos), 380);
    for (int i = 0; i < 5; i++) tick(4'b0000);
    check_val("both_low_pl", int'(pL_ypos), 0);
    check_val("both_low_pr", int'(pR_ypos), 380);

    // Randomized full games, each played to GAMEOVER
    for (int g = 0; g < 3; g++) begin
      if (g > 0) do_reset();
      n = 0;
      while (m_st != 2 && n < 20000) begin
        tick(rand_btn(g));
        n++;
      end
      check_val("reached_gameover", int'(game_state), 2);
      for (int i = 0; i < 10; i++) tick(rand_btn(0));
    end

    // Reset asserted mid-game
    do_reset();
    for (int i = 0; i < 150; i++) tick(rand_btn(0));
    do_reset();
    for (int i = 0; i < 35; i++) tick(rand_btn(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
